sigmoid_arbiter: RTL
====================

// Module: sigmoid_arbiter
// PURPOSE
//  Shares one sigmoid activation unit among N requesters (neurons) by round-robin.
//  A grant covers one whole transaction: ARG -> RES, then ERR -> FBK if training.
//  Routes the forward result and backward feedback to the granted port only.
//  Latches train per transaction, so the unit sees a stable train for the whole sequence.
// PARAMETERS
//  N      4   number of requester ports (2..16)
//  IW     $clog2(N)   grant index width (derived; do not override)
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low (0 = reset)
//  train       in   1       global training mode, sampled at grant
//  arg_valid   in   N       per-port argument valid
//  arg_data    in   N x 16  per-port signed Q8.8 argument (packed [N-1:0][15:0])
//  arg_ready   out  N       per-port argument ready
//  res_valid   out  N       per-port result valid
//  res_data    out  8       result, shared bus (valid only on the granted port)
//  res_ready   in   N       per-port result ready
//  err_valid   in   N       per-port error valid
//  err_data    in   N x 16  per-port signed error (packed [N-1:0][15:0])
//  err_ready   out  N       per-port error ready
//  fbk_valid   out  N       per-port feedback valid
//  fbk_data    out  16      feedback, shared bus
//  fbk_ready   in   N       per-port feedback ready
//  u_train     out  1       to unit: latched train
//  u_arg_*, u_res_*, u_err_*, u_fbk_*   unit-side mirror of the above, single port
//  grant       out  IW      index of the current or last granted port
//  busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs go to 0 immediately. state=IDLE, train_q=0, grant=0.
//   rr pointer = N-1, so port 0 has first priority.
//  Reset must be asserted together with the unit's reset. An aborted transaction is discarded.
//  States: IDLE, ARG, RES, ERR, FBK (registered).
//  IDLE: if any arg_valid, grant <= first requesting port after the rr pointer (wrapping).
//   Also train_q <= train, then go to ARG. The arbitration cycle costs 1 cycle.
//   With no request, stay in IDLE.
//  ARG: u_arg_valid = arg_valid[grant]; u_arg_data = arg_data[grant];
//   arg_ready[grant] = u_arg_ready. Go to RES on u_arg_valid & u_arg_ready.
//  RES: res_valid[grant] = u_res_valid; res_data = u_res_data; u_res_ready = res_ready[grant].
//   On that handshake: go to ERR if train_q, else go to IDLE.
//  ERR: routes err_* the same way as ARG. Go to FBK on handshake.
//  FBK: routes fbk_* the same way as RES. Go to IDLE on handshake.
//  On every return to IDLE: rr pointer <= grant.
//  All routing is combinational. Non-granted ports see ready=0 and valid=0.
//  In IDLE, every ready/valid toward both sides is 0.
//  u_train = train_q for the whole transaction. Changes on train are ignored until the next IDLE.
//  Requesters must hold valid and data until the handshake. The grant is never revoked.
//  Requests arriving mid-transaction wait. No port is skipped: a requester waits at most N-1 transactions.
//  Data passes through unmodified; the block does no arithmetic on data.
// TESTING
//  1 One port: port 2 sends arg 0x0000, train=0 -> unit sees 0x0000, res_valid[2]=1 with res_data=0x80.
//    Then back to IDLE; err_ready stays 0 throughout.
//  2 After reset, all 4 ports hold arg_valid -> grant order is 0,1,2,3,0.
//    No arg_ready to a non-granted port.
//  3 Training on port 1: arg 0x0000, err 0x0100 -> res 0x80, then fbk_valid[1] with fbk_data=0x0040.
//  4 train drops to 0 in the RES state of a training transaction -> u_train stays 1; ERR/FBK still run.
//  5 res_ready[g]=0 for 5 cycles -> res_valid[g] holds with stable data.
//    busy=1; no other port is granted.
//  6 Reset asserted in the ERR state -> outputs are 0 in the same cycle.
//    After release with ports 0 and 3 requesting, port 0 is granted first.

Source files
------------

// File: rtl/sigmoid_arbiter_if.sv
// Handshake bundle between requesters and the arbiter, and between the arbiter and the sigmoid unit.
// The unit side uses N = 1; the argument and error data are then a single 16-bit word.
interface sigmoid_arbiter_if #(
  parameter int N = 4
);
  // Every channel is valid/ready: a transfer happens on a rising clock edge where both are 1.
  // The sender holds valid and data stable until that edge. Ready may depend on valid.
  logic [N-1:0]       arg_valid;
  logic [N-1:0][15:0] arg_data;
  logic [N-1:0]       arg_ready;
  logic [N-1:0]       res_valid;
  logic [7:0]         res_data;
  logic [N-1:0]       res_ready;
  logic [N-1:0]       err_valid;
  logic [N-1:0][15:0] err_data;
  logic [N-1:0]       err_ready;
  logic [N-1:0]       fbk_valid;
  logic [15:0]        fbk_data;
  logic [N-1:0]       fbk_ready;

  modport master (
    output arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );

  modport slave (
    input  arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin sharing of one sigmoid unit among N requesters. A grant spans a whole
// forward (ARG->RES) and, in training, backward (ERR->FBK) transaction.
module sigmoid_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   train,
  sigmoid_arbiter_if.slave       req,
  sigmoid_arbiter_if.master      unit,
  output logic                   u_train,
  output logic [IW-1:0]          grant,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARG  = 3'd1,
    S_RES  = 3'd2,
    S_ERR  = 3'd3,
    S_FBK  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            train_q;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;

  // Search starts just after the last served port so nobody waits more than N-1 transactions.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N);
      if (!found && req.arg_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req.arg_ready  = '0;
    req.res_valid  = '0;
    req.res_data   = '0;
    req.err_ready  = '0;
    req.fbk_valid  = '0;
    req.fbk_data   = '0;
    unit.arg_valid = '0;
    unit.arg_data  = '0;
    unit.res_ready = '0;
    unit.err_valid = '0;
    unit.err_data  = '0;
    unit.fbk_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (found) state_d = S_ARG;
      end
      S_ARG: begin
        unit.arg_valid[0]    = req.arg_valid[grant];
        unit.arg_data[0]     = req.arg_data[grant];
        req.arg_ready[grant] = unit.arg_ready[0];
        if (req.arg_valid[grant] && unit.arg_ready[0]) state_d = S_RES;
      end
      S_RES: begin
        req.res_valid[grant] = unit.res_valid[0];
        req.res_data         = unit.res_data;
        unit.res_ready[0]    = req.res_ready[grant];
        if (unit.res_valid[0] && req.res_ready[grant]) state_d = train_q ? S_ERR : S_IDLE;
      end
      S_ERR: begin
        unit.err_valid[0]    = req.err_valid[grant];
        unit.err_data[0]     = req.err_data[grant];
        req.err_ready[grant] = unit.err_ready[0];
        if (req.err_valid[grant] && unit.err_ready[0]) state_d = S_FBK;
      end
      S_FBK: begin
        req.fbk_valid[grant] = unit.fbk_valid[0];
        req.fbk_data         = unit.fbk_data;
        unit.fbk_ready[0]    = req.fbk_ready[grant];
        if (unit.fbk_valid[0] && req.fbk_ready[grant]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant   <= '0;
      train_q <= 1'b0;
      rr_ptr  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && found) begin
        grant   <= pick;
        train_q <= train;
      end
      if (state_q != S_IDLE && state_d == S_IDLE) rr_ptr <= grant;
    end
  end

  assign u_train   = train_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
